// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_VID = 1'b1
  } gnt_owner_e;

  localparam int RAM_LAT_DEF      = 2;
  localparam int CPU_MAX_WAIT_DEF = 4;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ram_arb_cpu_port.sv
// CPU side of the arbiter: strobe edge detection, request latch and the pending flag.
module ram_arb_cpu_port
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              mem_r_i,
  input  logic              mem_w_i,
  input  logic              busy_i,
  input  logic              take_i,
  output logic              pend_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              write_o
);

  logic              hist_r_q, hist_w_q;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              write_q, write_d;
  logic              rise_r, rise_w, capture;

  assign rise_r  = mem_r_i & ~hist_r_q;
  assign rise_w  = mem_w_i & ~hist_w_q;
  // New edges are dropped while a request is latched or being served.
  assign capture = (rise_r | rise_w) & ~pend_q & ~busy_i;

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    if (take_i) begin
      pend_d = 1'b0;
    end
    if (capture) begin
      pend_d  = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
      write_d = rise_w;
    end
  end

  // History resets high so a strobe already asserted at reset release is not an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_r_q <= 1'b1;
      hist_w_q <= 1'b1;
      pend_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      hist_r_q <= mem_r_i;
      hist_w_q <= mem_w_i;
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      write_q  <= write_d;
    end
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign write_o = write_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the CPU memory path and the video fetcher.
// state  | meaning
// IDLE   | no access; evaluate video/CPU grant
// ACCESS | RAM strobe held for RAM_LAT cycles, read data sampled on the last edge
// DONE   | one-cycle ack/ready pulse, strobes low
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 8,
  parameter int RAM_LAT      = RAM_LAT_DEF,
  parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuDataW,
  input  logic              iCpuMemR,
  input  logic              iCpuMemW,
  output logic [DATA_W-1:0] oCpuDataR,
  output logic              oCpuReady,
  input  logic              iVidReq,
  input  logic [ADDR_W-1:0] iVidAddr,
  output logic              oVidAck,
  output logic [DATA_W-1:0] oVidData,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [DATA_W-1:0] oRamDataW,
  output logic              oRamR,
  output logic              oRamW,
  input  logic [DATA_W-1:0] iRamDataR
);

  localparam logic [3:0] LAT_LOAD = 4'(RAM_LAT - 1);
  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  arb_state_e        state_q, state_d;
  gnt_owner_e        owner_q, owner_d;
  logic              write_q, write_d;
  logic [3:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;

  logic              cpu_pend, cpu_write, cpu_busy, cpu_take, starved;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;

  assign cpu_busy = (state_q != IDLE) && (owner_q == GNT_CPU);
  assign starved  = cpu_pend && (starve_q >= MAX_WAIT);

  ram_arb_cpu_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cpu_port (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .addr_i  (iCpuAddr),
    .data_i  (iCpuDataW),
    .mem_r_i (iCpuMemR),
    .mem_w_i (iCpuMemW),
    .busy_i  (cpu_busy),
    .take_i  (cpu_take),
    .pend_o  (cpu_pend),
    .addr_o  (cpu_addr),
    .data_o  (cpu_data),
    .write_o (cpu_write)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    cpu_take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (iVidReq && !starved) begin
          state_d    = ACCESS;
          owner_d    = GNT_VID;
          write_d    = 1'b0;
          lat_d      = LAT_LOAD;
          ram_addr_d = iVidAddr;
          if (cpu_pend) begin
            starve_d = sat_inc(starve_q, MAX_WAIT);
          end
        end else if (cpu_pend) begin
          state_d     = ACCESS;
          owner_d     = GNT_CPU;
          write_d     = cpu_write;
          lat_d       = LAT_LOAD;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_data;
          starve_d    = '0;
          cpu_take    = 1'b1;
        end
      end
      ACCESS: begin
        if (lat_q == 4'd0) begin
          state_d = DONE;
          if (owner_q == GNT_VID) begin
            vid_data_d = iRamDataR;
          end else if (!write_q) begin
            cpu_rdata_d = iRamDataR;
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!cpu_pend) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      owner_q     <= GNT_CPU;
      write_q     <= 1'b0;
      lat_q       <= '0;
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
    end
  end

  assign oRamR     = (state_q == ACCESS) && !write_q;
  assign oRamW     = (state_q == ACCESS) && write_q;
  assign oRamAddr  = ram_addr_q;
  assign oRamDataW = ram_wdata_q;
  assign oVidAck   = (state_q == DONE) && (owner_q == GNT_VID);
  assign oCpuReady = (state_q == DONE) && (owner_q == GNT_CPU);
  assign oVidData  = vid_data_q;
  assign oCpuDataR = cpu_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random stimulus for ram_arbiter, checked each cycle against a transaction-timeline model.
module tb_ram_arbiter;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int L  = 2;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] iCpuAddr, iVidAddr, oRamAddr;
  logic [DW-1:0] iCpuDataW, oCpuDataR, oVidData, oRamDataW, iRamDataR;
  logic          iCpuMemR, iCpuMemW, oCpuReady, iVidReq, oVidAck, oRamR, oRamW;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(L), .CPU_MAX_WAIT(MW)) dut (
    .iClk(clk), .iRst(rst),
    .iCpuAddr(iCpuAddr), .iCpuDataW(iCpuDataW), .iCpuMemR(iCpuMemR), .iCpuMemW(iCpuMemW),
    .oCpuDataR(oCpuDataR), .oCpuReady(oCpuReady),
    .iVidReq(iVidReq), .iVidAddr(iVidAddr), .oVidAck(oVidAck), .oVidData(oVidData),
    .oRamAddr(oRamAddr), .oRamDataW(oRamDataW), .oRamR(oRamR), .oRamW(oRamW),
    .iRamDataR(iRamDataR)
  );

  always #5 clk = ~clk;

  // Environment RAM, written only by the DUT's strobes; mem_m is the model's own copy.
  logic [DW-1:0] ram   [0:(1<<AW)-1];
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  always @(posedge clk) if (oRamW) ram[oRamAddr] <= oRamDataW;
  assign iRamDataR = ram[oRamAddr];

  // Model: an access granted in cycle g strobes g+1..g+L and completes at g+L+1.
  bit            m_busy, m_vid, m_wr, m_pend, m_pwr, m_prev_r, m_prev_w;
  int            m_g, m_starve, cyc;
  logic [AW-1:0] m_aaddr, m_paddr, e_addr;
  logic [DW-1:0] m_adata, m_pdata, e_wdata, e_cpu, e_vid;
  int            vectors = 0, miscompares = 0, n_ack = 0, n_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_vid = 0; m_wr = 0; m_pend = 0; m_pwr = 0; m_starve = 0;
    m_prev_r = 1; m_prev_w = 1;
    e_addr = '0; e_wdata = '0; e_cpu = '0; e_vid = '0;
  endtask

  task automatic check();
    bit strobe, done;
    strobe = m_busy && (cyc >= m_g + 1) && (cyc <= m_g + L);
    done   = m_busy && (cyc == m_g + L + 1);
    if (done && m_vid) e_vid = mem_m[m_aaddr];
    if (done && !m_vid && !m_wr) e_cpu = mem_m[m_aaddr];
    chk("ram_r", 32'(oRamR), 32'(strobe && !m_wr));
    chk("ram_w", 32'(oRamW), 32'(strobe && m_wr));
    chk("ram_addr", 32'(oRamAddr), 32'(e_addr));
    if (strobe && m_wr) chk("ram_wdata", 32'(oRamDataW), 32'(e_wdata));
    chk("vid_ack", 32'(oVidAck), 32'(done && m_vid));
    chk("cpu_ready", 32'(oCpuReady), 32'(done && !m_vid));
    chk("cpu_rdata", 32'(oCpuDataR), 32'(e_cpu));
    if (done && m_vid) chk("vid_data", 32'(oVidData), 32'(e_vid));
    if (oVidAck) n_ack++;
    if (oCpuReady) n_rdy++;
  endtask

  task automatic update();
    bit rise_r, rise_w, pend0, inflight, cap;
    if (rst) begin
      if (m_busy && !m_vid && m_wr && cyc >= m_g + 1) mem_m[m_aaddr] = m_adata;
      model_reset();
    end else begin
      rise_r   = iCpuMemR && !m_prev_r;
      rise_w   = iCpuMemW && !m_prev_w;
      pend0    = m_pend;
      inflight = m_busy && !m_vid;
      cap      = (rise_r || rise_w) && !pend0 && !inflight;
      if (m_busy && cyc == m_g + L + 1) begin
        if (m_wr && !m_vid) mem_m[m_aaddr] = m_adata;
        m_busy = 0;
      end else if (!m_busy) begin
        if (iVidReq && !(pend0 && m_starve >= MW)) begin
          m_busy = 1; m_g = cyc; m_vid = 1; m_wr = 0;
          m_aaddr = iVidAddr; e_addr = iVidAddr;
          if (pend0 && m_starve < MW) m_starve++;
        end else if (pend0) begin
          m_busy = 1; m_g = cyc; m_vid = 0; m_wr = m_pwr;
          m_aaddr = m_paddr; m_adata = m_pdata; e_addr = m_paddr; e_wdata = m_pdata;
          m_pend = 0; m_starve = 0;
        end
      end
      if (!pend0) m_starve = 0;
      if (cap) begin
        m_pend = 1; m_pwr = rise_w; m_paddr = iCpuAddr; m_pdata = iCpuDataW;
      end
      m_prev_r = iCpuMemR; m_prev_w = iCpuMemW;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  initial begin
    int a0, r0, idx_ack, idx_rdy, waited;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = 8'(i ^ (i >> 8) ^ (i >> 16) ^ 8'h5A);
      mem_m[i] = 8'(i ^ (i >> 8) ^ (i >> 16) ^ 8'h5A);
    end
    rst = 1; iCpuAddr = '0; iCpuDataW = '0; iCpuMemR = 0; iCpuMemW = 0;
    iVidReq = 0; iVidAddr = '0;
    @(posedge clk); #1;
    cyc = 0; model_reset();
    repeat (2) step();
    rst = 0;
    step();

    // CPU write alone
    r0 = n_rdy;
    iCpuAddr = 20'h01234; iCpuDataW = 8'h5A; iCpuMemW = 1;
    repeat (6) step();
    chk("t1_ready_count", 32'(n_rdy - r0), 32'd1);
    iCpuMemW = 0;
    step();

    // CPU read, data held afterwards
    ram[20'h00400] = 8'hC3; mem_m[20'h00400] = 8'hC3;
    iCpuAddr = 20'h00400; iCpuMemR = 1;
    repeat (6) step();
    iCpuMemR = 0;
    repeat (10) step();
    chk("t2_rdata_held", 32'(oCpuDataR), 32'h0C3);

    // Simultaneous video and CPU requests: video first
    iVidReq = 1; iVidAddr = 20'hB8000; iCpuAddr = 20'h00777; iCpuMemR = 1;
    idx_ack = -1; idx_rdy = -1; a0 = n_ack; r0 = n_rdy;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) iVidReq = 0;
      if (idx_ack < 0 && n_ack != a0) idx_ack = i;
      if (idx_rdy < 0 && n_rdy != r0) idx_rdy = i;
    end
    chk("t3_vid_ack_cycle", 32'(idx_ack), 32'd3);
    chk("t3_cpu_ready_cycle", 32'(idx_rdy), 32'd7);
    iCpuMemR = 0;
    step();

    // Starvation bound under a continuous video request
    iVidReq = 1; iVidAddr = 20'h12345;
    step();
    iCpuAddr = 20'h0ABCD; iCpuMemR = 1;
    a0 = n_ack; r0 = n_rdy; waited = 0;
    while (n_rdy == r0 && waited < 60) begin
      step();
      waited++;
    end
    chk("t4_cpu_served", 32'(n_rdy - r0), 32'd1);
    // includes the video access already in flight when the CPU request was posted
    chk("t4_vid_acks_before_cpu", 32'(n_ack - a0), 32'(MW + 1));
    a0 = n_ack; r0 = n_rdy;
    repeat (32) step();
    chk("t4_vid_acks_after", 32'(n_ack - a0), 32'd8);
    chk("t4_no_extra_cpu", 32'(n_rdy - r0), 32'd0);
    iVidReq = 0; iCpuMemR = 0;
    repeat (6) step();

    // Edge during an in-flight read is ignored; dual edge performs a write
    r0 = n_rdy;
    iCpuAddr = 20'h03030; iCpuMemR = 1;
    step(); step();
    iCpuMemR = 0; step();
    iCpuMemR = 1; iCpuAddr = 20'h04040; step();
    iCpuMemR = 0;
    repeat (6) step();
    chk("t5_single_read", 32'(n_rdy - r0), 32'd1);
    iCpuAddr = 20'h02222; iCpuDataW = 8'h99; iCpuMemR = 1; iCpuMemW = 1;
    repeat (6) step();
    iCpuMemR = 0; iCpuMemW = 0;
    iCpuAddr = 20'h02222; step();
    iCpuMemR = 1; repeat (6) step();
    chk("t5_dual_wrote", 32'(oCpuDataR), 32'h099);
    iCpuMemR = 0; step();

    // Reset in the first strobe cycle; strobe held through reset release
    a0 = n_ack; r0 = n_rdy;
    iCpuAddr = 20'h05555; iCpuDataW = 8'h11; iCpuMemW = 1;
    step(); step();
    rst = 1; step();
    rst = 0;
    repeat (8) step();
    chk("t6_no_ready", 32'(n_rdy - r0), 32'd0);
    chk("t6_no_ack", 32'(n_ack - a0), 32'd0);
    chk("t6_rdata_reset", 32'(oCpuDataR), 32'd0);
    iCpuMemW = 0; step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(399) == 0);
      iVidReq   = ($urandom_range(2) == 0);
      iVidAddr  = AW'($urandom);
      iCpuAddr  = AW'($urandom);
      iCpuDataW = DW'($urandom);
      if ($urandom_range(5) == 0) iCpuMemR = ~iCpuMemR;
      if ($urandom_range(5) == 0) iCpuMemW = ~iCpuMemW;
      step();
    end
    rst = 0; iVidReq = 0; iCpuMemR = 0; iCpuMemW = 0;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single external RAM port between two requesters: the CPU memory path (level MemR/MemW strobes, address and write data) and a video fetch port (req/ack). Sits between the system top level and the oCpuRam* pins. CPU accesses outside the BIOS window are routed through it, and the CGA/text fetcher reads video memory through it. Fixed video priority, with a starvation bound that guarantees CPU service.

Parameters:
ADDR_W, 20, RAM address width
DATA_W, 8, RAM data width
RAM_LAT, 2, cycles the RAM strobe is held per access (range 1..15)
CPU_MAX_WAIT, 4, maximum consecutive video grants while a CPU request is pending (range 1..15)

Ports:
iClk  in  1  system clock
iRst  in  1  synchronous active-high reset
iCpuAddr  in  ADDR_W  CPU address (latched address from the CPU bus)
iCpuDataW  in  DATA_W  CPU write data
iCpuMemR  in  1  CPU memory read strobe, level, 1 = read
iCpuMemW  in  1  CPU memory write strobe, level, 1 = write
oCpuDataR  out  DATA_W  last CPU read data, held until the next CPU read completes
oCpuReady  out  1  one-cycle pulse when a CPU access completes
iVidReq  in  1  video read request, level
iVidAddr  in  ADDR_W  video read address
oVidAck  out  1  one-cycle pulse; oVidData is valid in the same cycle
oVidData  out  DATA_W  video read data
oRamAddr  out  ADDR_W  RAM address
oRamDataW  out  DATA_W  RAM write data
oRamR  out  1  RAM read strobe
oRamW  out  1  RAM write strobe
iRamDataR  in  DATA_W  RAM read data

Behaviour:
- Clock and reset: single clock iClk. iRst is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, cpuPend cleared, starvation counter cleared.
- Reset edge-detect history: the edge-detect history registers reset to 1. A strobe already high when reset releases does not create a request.
- CPU capture: a rising edge of iCpuMemR or iCpuMemW sets cpuPend and latches address, data and direction that cycle.
  - If both strobes rise in the same cycle, the write is taken.
  - Any edge while cpuPend=1 or a CPU access is in flight is ignored; the latched request is preserved.
- Video request: iVidReq is sampled only in IDLE. iVidAddr is latched at grant.
  - The requester must deassert iVidReq in the cycle after oVidAck. If it stays high, that counts as a new request.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE grant, evaluated in cycle T:
  - iVidReq && !(cpuPend && starve >= CPU_MAX_WAIT): grant video and increment starve if cpuPend.
  - else if cpuPend: grant CPU, clear cpuPend, clear starve.
  - else stay in IDLE.
  - If both first become pending in the same cycle, video wins.
- ACCESS: cycles T+1..T+RAM_LAT.
  - oRamAddr/oRamDataW are driven from the latched request.
  - oRamR or oRamW is held high for exactly RAM_LAT cycles.
  - iRamDataR is sampled at the clock edge ending cycle T+RAM_LAT.
- DONE: cycle T+RAM_LAT+1.
  - Pulse oVidAck with oVidData, or pulse oCpuReady and update oCpuDataR (reads only).
  - oCpuReady also pulses for writes.
  - Strobes are low.
- Throughput: the next grant is possible at T+RAM_LAT+2, so each access occupies RAM_LAT+2 cycles.
- Starvation counter: saturates at CPU_MAX_WAIT. It is cleared on CPU grant and when cpuPend=0.
- Idle outputs: oRamAddr holds its last value. Strobes are 0.
- Reset mid-access: abandon the access. Strobes are 0 the cycle after iRst is sampled. No ack or ready pulse. cpuPend is cleared.

Decomposition:
- Shared package: FSM state enum (IDLE, ACCESS, DONE), grant-owner encoding (GNT_CPU, GNT_VID), default RAM_LAT and CPU_MAX_WAIT constants.
- One natural sub-module: ram_arb_cpu_port, which holds the strobe edge detectors, the request latch and the cpuPend flag.
- Grant logic and FSM stay in ram_arbiter.

Test Plan:
1. CPU write alone: iCpuAddr=0x01234, iCpuDataW=0x5A, iCpuMemW rises at cycle 0.
   - Grant at cycle 1; oRamW=1 at cycles 2-3 with oRamAddr=0x01234, oRamDataW=0x5A.
   - oCpuReady pulses at cycle 4.
2. CPU read: RAM returns 0xC3 at address 0x00400.
   - oRamR high for 2 cycles; oCpuReady pulses with oCpuDataR=0xC3.
   - oCpuDataR still 0xC3 after 10 idle cycles.
3. Simultaneous requests: iVidReq and a CPU read edge in the same cycle, iVidAddr=0xB8000.
   - Video is served first (oVidAck after 4 cycles), then the CPU; total 8 cycles to oCpuReady.
4. Starvation: iVidReq held high continuously, then a CPU read posted.
   - Exactly 4 video acks, then the CPU grant; the pattern repeats with no further CPU request.
5. Ignored edge and dual edge:
   - A second iCpuMemR edge during an in-flight CPU read produces no extra RAM access.
   - MemR and MemW rising together performs a write.
6. Reset mid-ACCESS: iRst asserted in the first strobe cycle.
   - Strobes are 0 the next cycle; no oCpuReady or oVidAck.
   - A strobe held high through reset release produces no access.
